// File: rtl/poly_result_reader_if.sv
// rtl/poly_result_reader_if.sv - host request/beat handshake and result-memory read bus
interface poly_result_reader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int RAMWIDTH   = 32
);
    logic                  req_i;
    logic [9:0]            key_i;
    logic [7:0]            len_i;
    logic                  mem_rd_en_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [RAMWIDTH-1:0]   mem_dout_i;
    logic [127:0]          data_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;

    modport slave (
        input  req_i, key_i, len_i, mem_dout_i, ready_i,
        output mem_rd_en_o, mem_addr_o, data_o, valid_o, busy_o, done_o, err_o
    );

    modport master (
        output req_i, key_i, len_i, mem_dout_i, ready_i,
        input  mem_rd_en_o, mem_addr_o, data_o, valid_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/poly_result_reader.sv
// rtl/poly_result_reader.sv - reads len 4-word groups from the result memory and returns them as 128-bit beats
module poly_result_reader #(
    parameter int DEPTH      = 553,
    parameter int RAMWIDTH   = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst,
    poly_result_reader_if.slave bus
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cur;
    logic [7:0]      remaining;
    logic [2:0]      issue_cnt;
    logic            s1_vld, s2_vld, s1_ok, s2_ok;
    logic [1:0]      s1_idx, s2_idx;
    logic            accept, issue, handshake, last_cap, in_range;
    logic [CW-1:0]   rd_addr;
    logic [RAMWIDTH-1:0] word;

    always_comb begin
        accept    = (state == IDLE) && bus.req_i && (bus.len_i != 8'd0);
        issue     = (state == FETCH) && !issue_cnt[2];
        handshake = (state == HOLD) && bus.valid_o && bus.ready_i;
        last_cap  = s2_vld && (s2_idx == 2'd3);
        rd_addr   = cur + CW'(issue_cnt);
        in_range  = rd_addr < CW'(DEPTH);
        word      = s2_ok ? bus.mem_dout_i : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = FETCH;
            FETCH: if (last_cap) state_nxt = HOLD;
            HOLD:  if (handshake) state_nxt = (remaining > 8'd1) ? FETCH : DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read tags travel two stages: issue register, then the memory's own read cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur             <= '0;
            remaining       <= '0;
            issue_cnt       <= '0;
            s1_vld          <= 1'b0;
            s1_ok           <= 1'b0;
            s1_idx          <= '0;
            s2_vld          <= 1'b0;
            s2_ok           <= 1'b0;
            s2_idx          <= '0;
            bus.mem_rd_en_o <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.data_o      <= '0;
            bus.valid_o     <= 1'b0;
            bus.busy_o      <= 1'b0;
            bus.done_o      <= 1'b0;
            bus.err_o       <= 1'b0;
        end else begin
            bus.done_o      <= 1'b0;
            bus.mem_rd_en_o <= 1'b0;
            s1_vld          <= issue;
            s2_vld          <= s1_vld;
            s2_ok           <= s1_ok;
            s2_idx          <= s1_idx;

            if (accept) begin
                cur         <= CW'(bus.key_i);
                remaining   <= bus.len_i;
                issue_cnt   <= '0;
                bus.err_o   <= 1'b0;
                bus.busy_o  <= 1'b1;
            end

            if (issue) begin
                bus.mem_rd_en_o <= in_range;
                if (in_range) bus.mem_addr_o <= rd_addr[ADDR_WIDTH-1:0];
                else          bus.err_o      <= 1'b1;
                issue_cnt <= issue_cnt + 3'd1;
                s1_ok     <= in_range;
                s1_idx    <= issue_cnt[1:0];
            end

            if (s2_vld) begin
                bus.data_o[32*s2_idx +: 32] <= word[31:0];
                if (last_cap) bus.valid_o <= 1'b1;
            end

            if (handshake) begin
                bus.valid_o <= 1'b0;
                cur         <= cur + CW'(4);
                remaining   <= remaining - 8'd1;
                issue_cnt   <= '0;
            end

            if (state == DONE) begin
                bus.done_o <= 1'b1;
                bus.busy_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_poly_result_reader.sv
// tb/tb_poly_result_reader.sv - randomized and directed bench for poly_result_reader
module tb_poly_result_reader;
    localparam int DEPTH = 553;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    poly_result_reader_if #(.ADDR_WIDTH(10), .RAMWIDTH(32)) bus ();
    poly_result_reader #(.DEPTH(DEPTH), .RAMWIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] mem_q = 32'd0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          bad_rd   = 0;
    logic [9:0]  rd_q [$];

    always @(posedge clk)
        if (bus.mem_rd_en_o && int'(bus.mem_addr_o) < DEPTH) mem_q <= mem[bus.mem_addr_o];
    assign bus.mem_dout_i = mem_q;

    always @(negedge clk)
        if (bus.mem_rd_en_o) begin
            rd_q.push_back(bus.mem_addr_o);
            if (int'(bus.mem_addr_o) >= DEPTH) bad_rd++;
        end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, bus.data_o, 128'd0);
        check({tag, "_flags"}, {bus.valid_o, bus.busy_o, bus.done_o, bus.err_o, bus.mem_rd_en_o}, 5'd0);
        check({tag, "_addr"}, bus.mem_addr_o, 10'd0);
    endtask

    task automatic run_xfer(input int key, input int len, input int hold, input bit poke);
        int           exp_addr [$];
        bit           exp_err = 0;
        bit           busy_ok = 1;
        bit           stable, seq_ok;
        logic [127:0] expd;
        int           cyc, a;
        for (int b = 0; b < len; b++)
            for (int j = 0; j < 4; j++) begin
                a = key + 4 * b + j;
                if (a < DEPTH) exp_addr.push_back(a);
                else           exp_err = 1;
            end
        rd_q.delete();
        @(negedge clk);
        bus.req_i = 1'b1; bus.key_i = 10'(key); bus.len_i = 8'(len);
        @(negedge clk);
        bus.req_i = 1'b0;
        for (int b = 0; b < len; b++) begin
            cyc = 0;
            while (!bus.valid_o && cyc < 12) begin
                if (!bus.busy_o) busy_ok = 0;
                @(negedge clk);
                cyc++;
                if (poke && b == 0 && cyc == 2) begin
                    bus.req_i = 1'b1;
                    bus.key_i = 10'($urandom_range(0, 1023));
                    bus.len_i = 8'($urandom_range(1, 255));
                end else bus.req_i = 1'b0;
            end
            check("beat_latency", cyc, 6);
            expd = '0;
            for (int j = 0; j < 4; j++) begin
                a = key + 4 * b + j;
                expd[32*j +: 32] = (a < DEPTH) ? mem[a] : 32'd0;
            end
            check("beat_data", bus.data_o, expd);
            stable = 1;
            bus.ready_i = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                if (!bus.valid_o || bus.data_o !== expd || bus.mem_rd_en_o || !bus.busy_o) stable = 0;
            end
            check("hold_stable", stable, 1);
            bus.ready_i = 1'b1;
            @(negedge clk);
            bus.ready_i = 1'b0;
            check("valid_drop", bus.valid_o, 0);
        end
        check("busy_during", busy_ok, 1);
        check("done_early", {bus.done_o, bus.busy_o}, 2'b01);
        @(negedge clk);
        check("done_pulse", {bus.done_o, bus.busy_o}, 2'b10);
        @(negedge clk);
        check("done_clear", bus.done_o, 0);
        check("err_flag", bus.err_o, exp_err);
        seq_ok = (rd_q.size() == exp_addr.size());
        if (seq_ok) foreach (rd_q[i]) if (int'(rd_q[i]) != exp_addr[i]) seq_ok = 0;
        check("rd_count", rd_q.size(), exp_addr.size());
        check("rd_sequence", seq_ok, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit idle_ok;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + i;
        rst = 1'b1;
        bus.req_i = 1'b0; bus.key_i = '0; bus.len_i = '0; bus.ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_xfer(0, 1, 0, 0);
        check("first_beat_const", bus.data_o, 128'h00000103_00000102_00000101_00000100);
        run_xfer(0, 1, 10, 0);
        run_xfer(8, 3, 2, 0);
        run_xfer(551, 1, 0, 0);
        run_xfer(0, 2, 1, 1);

        rd_q.delete();
        idle_ok = 1;
        @(negedge clk);
        bus.req_i = 1'b1; bus.key_i = 10'd5; bus.len_i = 8'd0;
        @(negedge clk);
        bus.req_i = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.busy_o || bus.valid_o) idle_ok = 0;
        end
        check("len0_ignored", idle_ok, 1);
        check("len0_no_reads", rd_q.size(), 0);

        @(negedge clk);
        bus.req_i = 1'b1; bus.key_i = 10'd0; bus.len_i = 8'd2;
        @(negedge clk);
        bus.req_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midfetch_rst");
        idle_ok = 1;
        repeat (6) begin
            @(negedge clk);
            if (bus.valid_o || bus.busy_o || bus.data_o !== 128'd0) idle_ok = 0;
        end
        check("inflight_dropped", idle_ok, 1);
        run_xfer(0, 1, 0, 0);

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int t = 0; t < 12; t++)
            run_xfer($urandom_range(0, DEPTH + 8), $urandom_range(1, 4),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)));

        check("oob_reads", bad_rd, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
